// File: rtl/button_pulser.sv
// Two-button conditioner: synchronize, debounce, edge-detect, chord-suppress.
// Define BUTTON_PULSER_AUTO_REPEAT_EN to add the hold/auto-repeat pulse train.
module button_pulser #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_raw,
  input  logic dec_raw,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic inc_level,
  output logic dec_level
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

`ifdef BUTTON_PULSER_AUTO_REPEAT_EN
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(TMR_MAX);
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  // Channel 0 is increment, channel 1 is decrement.
  logic [1:0] raw_vec;
  logic [1:0] level_vec;
  logic [1:0] level_next_vec;
  logic [1:0] pulse_vec;

  assign raw_vec = {dec_raw, inc_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic            sync1_reg;
      logic            sync2_reg;
      logic            level_reg;
      logic            level_next;
      logic [DB_W-1:0] db_cnt_reg;
      logic            commit;
      logic            press_evt;
      logic            other_busy;
      logic            pulse_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= raw_vec[gi];
          sync2_reg <= sync1_reg;
        end
      end

      assign commit     = (sync2_reg != level_reg) &&
                          (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1));
      assign level_next = commit ? sync2_reg : level_reg;
      assign press_evt  = commit & sync2_reg;

      // Any sample that agrees with the committed level restarts the window.
      always_ff @(posedge clk) begin
        if (reset) begin
          level_reg  <= 1'b0;
          db_cnt_reg <= '0;
        end else if (commit) begin
          level_reg  <= sync2_reg;
          db_cnt_reg <= '0;
        end else if (sync2_reg != level_reg) begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end else begin
          db_cnt_reg <= '0;
        end
      end

      // Use the other channel's post-edge level so simultaneous presses both drop.
      assign other_busy = level_next_vec[1 - gi];

`ifdef BUTTON_PULSER_AUTO_REPEAT_EN
      typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

      state_t           state_reg;
      logic [TMR_W-1:0] tmr_reg;
      logic             release_evt;

      assign release_evt = commit & ~sync2_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg <= IDLE;
          tmr_reg   <= '0;
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= 1'b0;
          case (state_reg)
            IDLE: begin
              tmr_reg <= '0;
              if (press_evt) begin
                state_reg <= HOLD;
                pulse_reg <= ~other_busy;
              end
            end
            HOLD: begin
              if (release_evt) begin
                state_reg <= IDLE;
                tmr_reg   <= '0;
              end else if (tmr_reg == TMR_W'(REPEAT_DELAY - 1)) begin
                state_reg <= REPEAT;
                tmr_reg   <= '0;
                pulse_reg <= ~other_busy;
              end else begin
                tmr_reg <= tmr_reg + 1'b1;
              end
            end
            REPEAT: begin
              if (release_evt) begin
                state_reg <= IDLE;
                tmr_reg   <= '0;
              end else if (tmr_reg == TMR_W'(REPEAT_PERIOD - 1)) begin
                tmr_reg   <= '0;
                pulse_reg <= ~other_busy;
              end else begin
                tmr_reg <= tmr_reg + 1'b1;
              end
            end
            default: begin
              state_reg <= IDLE;
              tmr_reg   <= '0;
            end
          endcase
        end
      end
`else
      always_ff @(posedge clk) begin
        if (reset) begin
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= press_evt & ~other_busy;
        end
      end
`endif

      assign level_vec[gi]      = level_reg;
      assign level_next_vec[gi] = level_next;
      assign pulse_vec[gi]      = pulse_reg;
    end
  endgenerate

  assign inc_pulse = pulse_vec[0];
  assign dec_pulse = pulse_vec[1];
  assign inc_level = level_vec[0];
  assign dec_level = level_vec[1];

endmodule

// File: tb/tb_button_pulser.sv
// Bench for button_pulser: per-cycle vector tables with hand-derived timing,
// expected outputs queued on drive and popped one edge later.
module tb_button_pulser;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;
`ifdef BUTTON_PULSER_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic inc_raw;
  logic dec_raw;
  logic inc_pulse;
  logic dec_pulse;
  logic inc_level;
  logic dec_level;

  always #5 clk = ~clk;

  button_pulser #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .inc_raw  (inc_raw),
    .dec_raw  (dec_raw),
    .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse),
    .inc_level(inc_level),
    .dec_level(dec_level)
  );

  // exp = {inc_pulse, dec_pulse, inc_level, dec_level} after the edge.
  typedef struct {
    logic       rst;
    logic       inc;
    logic       dec;
    logic [3:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];
  int         checks = 0;
  int         passed = 0;

  function automatic void add(input logic rst, input logic inc, input logic dec,
                              input logic ip, input logic dp, input logic il, input logic dl);
    vec_t v;
    v.rst = rst;
    v.inc = inc;
    v.dec = dec;
    v.exp = {ip, dp, il, dl};
    vecs.push_back(v);
  endfunction

  // Pulse at press edge p, then repeats p+RD, p+RD+RP, ... strictly before edge stop.
  function automatic logic rep_at(input int j, input int p, input int stop);
    if (j == p) return 1'b1;
    if (!AR) return 1'b0;
    return (j >= p + RD) && (j < stop) && (((j - p - RD) % RP) == 0);
  endfunction

  task automatic check_out(input string name, input int idx);
    logic [3:0] got;
    logic [3:0] want;
    got  = {inc_pulse, dec_pulse, inc_level, dec_level};
    want = exp_q.pop_front();
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s step %0d: ip/dp/il/dl got %b required %b", name, idx, got, want);
  endtask

  task automatic run_scenario(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      reset   = vecs[i].rst;
      inc_raw = vecs[i].inc;
      dec_raw = vecs[i].dec;
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      check_out(name, i);
    end
    vecs.delete();
  endtask

  initial begin
    reset   = 1'b1;
    inc_raw = 1'b0;
    dec_raw = 1'b0;
    #1;

    // Reset state
    for (int j = 0; j < 3; j++) add(1, 0, 0, 0, 0, 0, 0);
    run_scenario("reset");

    // Clean press: raw high at edges 10..17, level 15..22, single pulse at 15
    for (int j = 0; j < 30; j++)
      add(0, (j >= 10 && j < 18), 0, (j == 15), 0, (j >= 15 && j < 23), 0);
    run_scenario("clean_press");

    // Bounce on dec: 1,0,1,1,0 then 1 from edge 5 to 13; level 10..18
    for (int j = 0; j < 30; j++) begin
      logic r;
      r = (j == 0 || j == 2 || j == 3 || (j >= 5 && j < 14));
      add(0, 0, r, 0, (j == 10), 0, (j >= 10 && j < 19));
    end
    run_scenario("bounce");

    // Auto-repeat: held 40 cycles, press at 5, release commits at 45
    for (int j = 0; j < 60; j++)
      add(0, (j < 40), 0, rep_at(j, 5, 45), 0, (j >= 5 && j < 45), 0);
    run_scenario("auto_repeat");

    // Chord: both pressed together; dec released (commits 37); inc resumes schedule
    for (int j = 0; j < 75; j++)
      add(0, (j < 60), (j < 32), (j >= 37) && rep_at(j, 5, 65), 0,
          (j >= 5 && j < 65), (j >= 5 && j < 37));
    run_scenario("chord");

    // Reset mid-repeat at edge 22 with inc held; fresh press 6 edges later
    for (int j = 0; j < 60; j++) begin
      logic ip;
      ip = (j < 22) ? rep_at(j, 5, 22) : rep_at(j, 28, 50);
      add((j == 22), (j < 45), 0, ip, 0, (j >= 5 && j < 22) || (j >= 28 && j < 50), 0);
    end
    run_scenario("reset_mid_repeat");

    // Dec channel alone: held 20 cycles, press at 5, release commits at 25
    for (int j = 0; j < 35; j++)
      add(0, 0, (j < 20), 0, rep_at(j, 5, 25), 0, (j >= 5 && j < 25));
    run_scenario("dec_repeat");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
